eval_exp_fp32_128_sched: RTL
============================

EVAL_EXP_FP32_128_SCHED -- requirements
Module: eval_exp_fp32_128_sched

Interface
REQ-001 SHALL have parameter DEVICE, default "ULTRASCALE_PLUS", target device family.
REQ-002 SHALL have parameter SIMULATION, default "false", simulation-only behaviour select.
REQ-003 SHALL have parameter DEBUG, default "false", debug attribute enable.
REQ-004 SHALL have parameter ADDR_BITS, default 40, byte-address width.
REQ-005 SHALL have parameter LEN_BITS, default 16, block-count width.
REQ-006 SHALL have parameter MAX_OUTSTANDING, default 4, blocks in flight limit (1..15).
REQ-007 SHALL use one clock and an asynchronous active-low reset, with these ports:
- aresetn  in  1  async active-low reset.
- aclk  in  1  clock.
- s_start  in  1  start pulse.
- s_src_addr  in  ADDR_BITS  source base address.
- s_dst_addr  in  ADDR_BITS  destination base address.
- s_blocks  in  LEN_BITS  number of 512-byte blocks (128 x fp32).
- busy  out  1  job active.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky spurious-completion flag.
- m_rd_addr  out  ADDR_BITS  read request address.
- m_rd_valid  out  1  read request valid.
- m_rd_ready  in  1  read request accept.
- rd_cmpl  in  1  pulse: one block has entered the exp datapath.
- m_wr_addr  out  ADDR_BITS  write request address.
- m_wr_valid  out  1  write request valid.
- m_wr_ready  in  1  write request accept.
- wr_cmpl  in  1  pulse: one block has been written to memory.

Function
REQ-008 SHALL implement an FSM with states IDLE, RUN and DONE.
- IDLE->RUN on s_start with s_blocks!=0.
- IDLE->DONE on s_start with s_blocks==0.
- RUN->DONE when the write-completion count equals the job length.
- DONE->IDLE unconditionally after one cycle.
REQ-009 SHALL latch s_src_addr, s_dst_addr and s_blocks on accepted s_start; s_start outside IDLE is ignored.
REQ-010 SHALL assert busy in RUN and DONE, and raise m_rd_valid in the cycle after s_start (latency 1).
REQ-011 SHALL raise done only in DONE; busy falls in the same cycle, so a zero-length job gives done at start+1 with no requests issued.
REQ-012 SHALL keep m_rd_valid and m_rd_addr stable until m_rd_ready is sampled high (AXI-style; same rule for the write channel).
REQ-013 SHALL advance m_rd_addr by 512 on each accepted read request, wrapping modulo 2^ADDR_BITS; m_wr_addr advances likewise.
REQ-014 SHALL assert m_rd_valid only while reads issued < s_blocks and (reads issued - writes completed) < MAX_OUTSTANDING.
REQ-015 SHALL assert m_wr_valid only while writes issued < read completions.
REQ-016 SHALL count rd_cmpl and wr_cmpl in the same cycle independently, with both counts taking effect.
REQ-017 SHALL ignore any rd_cmpl exceeding reads issued, or wr_cmpl exceeding writes issued (including any in IDLE), and set err, which clears only on reset.
REQ-018 SHALL size all counters at LEN_BITS; the outstanding count SHALL be sized at $clog2(MAX_OUTSTANDING+1).

Reset
REQ-019 SHALL, on aresetn low at any time including mid-job, asynchronously reset as follows:
- FSM to IDLE.
- all counters to 0.
- busy, done, err, m_rd_valid, m_wr_valid to 0.
- m_rd_addr, m_wr_addr to 0.
REQ-020 SHALL not issue any request before the first aclk edge after aresetn rises.

Configuration
REQ-021 SHALL, with EVAL_EXP_SCHED_CYCLE_COUNT_EN defined, add output cycle_count (32 bits), which:
- clears on accepted s_start.
- increments every cycle while busy, saturating at all-ones.
- holds after done.
REQ-022 SHALL, with EVAL_EXP_SCHED_CYCLE_COUNT_EN undefined, provide neither the port nor its logic.

Structure
REQ-023 SHALL place BLOCK_BYTES=512, LANES=128 and the FSM state enum in package eval_exp_fp32_128_sched_pkg.
REQ-024 SHALL use one sub-module, eval_exp_fp32_128_req_gen, instantiated twice (read, write); it implements address increment, the valid/ready hold and the issued count.

Verification
REQ-025 SHALL verify zero-length job: s_blocks=0 -> done at start+1, m_rd_valid and m_wr_valid never high.
REQ-026 SHALL verify a 3-block job with ready always 1, src=0x1000, dst=0x8000 -> rd addrs 0x1000/0x1200/0x1400, wr addrs 0x8000/0x8200/0x8400, then done after the 3rd wr_cmpl.
REQ-027 SHALL verify throttling: MAX_OUTSTANDING=4, 10 blocks, wr_cmpl withheld -> exactly 4 reads accepted, m_rd_valid low until a wr_cmpl arrives.
REQ-028 SHALL verify backpressure plus wrap: m_rd_ready low 5 cycles with src=2^40-512 -> address held stable, next address 0.
REQ-029 SHALL verify simultaneous/spurious completions: rd_cmpl and wr_cmpl in the same cycle both counted; an extra wr_cmpl sets err while counts are unchanged.
REQ-030 SHALL verify reset mid-job: aresetn low after 2 of 5 blocks -> all outputs 0 immediately, new job restarts from its own base addresses.

Source files
------------

// File: rtl/eval_exp_fp32_128_sched_pkg.sv
// Shared constants and FSM encoding for the fp32 exp block scheduler.
package eval_exp_fp32_128_sched_pkg;

    localparam int unsigned LANES       = 128;
    localparam int unsigned FP32_BYTES  = 4;
    localparam int unsigned BLOCK_BYTES = LANES * FP32_BYTES;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/eval_exp_fp32_128_req_gen.sv
// Block request generator: walks a base address in BLOCK_BYTES steps and counts issued requests.
module eval_exp_fp32_128_req_gen
    import eval_exp_fp32_128_sched_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 40,
    parameter int unsigned LEN_BITS  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [ADDR_BITS-1:0] base_i,
    input  logic                 allow_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic                 fire_o,
    output logic [ADDR_BITS-1:0] addr_o,
    output logic [LEN_BITS-1:0]  issued_o
);

    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [LEN_BITS-1:0]  issued_q, issued_d;

    // allow_i can only drop when a request fires, so valid/addr hold while ready is low.
    assign valid_o  = allow_i;
    assign fire_o   = allow_i & ready_i;
    assign addr_o   = addr_q;
    assign issued_o = issued_q;

    always_comb begin
        addr_d   = addr_q;
        issued_d = issued_q;
        if (load_i) begin
            addr_d   = base_i;
            issued_d = '0;
        end else if (fire_o) begin
            addr_d   = addr_q + ADDR_BITS'(BLOCK_BYTES);
            issued_d = issued_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            issued_q <= '0;
        end else begin
            addr_q   <= addr_d;
            issued_q <= issued_d;
        end
    end

endmodule

// File: rtl/eval_exp_fp32_128_sched.sv
// Read/write block scheduler for the 128-lane fp32 exp engine.
// Optional EVAL_EXP_SCHED_CYCLE_COUNT_EN adds a saturating busy-cycle counter output.
module eval_exp_fp32_128_sched
    import eval_exp_fp32_128_sched_pkg::*;
#(
    parameter string       DEVICE          = "ULTRASCALE_PLUS",
    parameter string       SIMULATION      = "false",
    parameter string       DEBUG           = "false",
    parameter int unsigned ADDR_BITS       = 40,
    parameter int unsigned LEN_BITS        = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                 aresetn,
    input  logic                 aclk,
    input  logic                 s_start,
    input  logic [ADDR_BITS-1:0] s_src_addr,
    input  logic [ADDR_BITS-1:0] s_dst_addr,
    input  logic [LEN_BITS-1:0]  s_blocks,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_BITS-1:0] m_rd_addr,
    output logic                 m_rd_valid,
    input  logic                 m_rd_ready,
    input  logic                 rd_cmpl,
    output logic [ADDR_BITS-1:0] m_wr_addr,
    output logic                 m_wr_valid,
    input  logic                 m_wr_ready,
    input  logic                 wr_cmpl
`ifdef EVAL_EXP_SCHED_CYCLE_COUNT_EN
    ,
    output logic [31:0]          cycle_count
`endif
);

    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

    // Device/debug selectors are reserved hooks with no effect on the datapath.
    if (DEBUG == "true" && SIMULATION == "true" && DEVICE != "") begin : g_dbg_hooks
    end

    state_e              state_q, state_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [LEN_BITS-1:0] rd_done_q, rd_done_d;
    logic [LEN_BITS-1:0] wr_done_q, wr_done_d;
    logic [OutW-1:0]     outst_q, outst_d;
    logic                err_q, err_d;

    logic                start_acc;
    logic                rd_allow, wr_allow, rd_fire, wr_fire;
    logic                rd_cmpl_ok, wr_cmpl_ok;
    logic [LEN_BITS-1:0] rd_issued, wr_issued;

    assign start_acc = s_start && (state_q == StIdle);

    // Completions in IDLE or beyond the issued count are spurious.
    assign rd_cmpl_ok = rd_cmpl && (state_q != StIdle) && (rd_done_q < rd_issued);
    assign wr_cmpl_ok = wr_cmpl && (state_q != StIdle) && (wr_done_q < wr_issued);

    assign rd_allow = (state_q == StRun) && (rd_issued < len_q)
                      && (outst_q < OutW'(MAX_OUTSTANDING));
    assign wr_allow = (state_q == StRun) && (wr_issued < rd_done_q);

    eval_exp_fp32_128_req_gen #(
        .ADDR_BITS (ADDR_BITS),
        .LEN_BITS  (LEN_BITS)
    ) u_rd_gen (
        .clk_i    (aclk),
        .rst_ni   (aresetn),
        .load_i   (start_acc),
        .base_i   (s_src_addr),
        .allow_i  (rd_allow),
        .ready_i  (m_rd_ready),
        .valid_o  (m_rd_valid),
        .fire_o   (rd_fire),
        .addr_o   (m_rd_addr),
        .issued_o (rd_issued)
    );

    eval_exp_fp32_128_req_gen #(
        .ADDR_BITS (ADDR_BITS),
        .LEN_BITS  (LEN_BITS)
    ) u_wr_gen (
        .clk_i    (aclk),
        .rst_ni   (aresetn),
        .load_i   (start_acc),
        .base_i   (s_dst_addr),
        .allow_i  (wr_allow),
        .ready_i  (m_wr_ready),
        .valid_o  (m_wr_valid),
        .fire_o   (wr_fire),
        .addr_o   (m_wr_addr),
        .issued_o (wr_issued)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rd_done_d = rd_done_q;
        wr_done_d = wr_done_q;
        outst_d   = outst_q;
        err_d     = err_q | (rd_cmpl & ~rd_cmpl_ok) | (wr_cmpl & ~wr_cmpl_ok);

        if (start_acc) begin
            len_d     = s_blocks;
            rd_done_d = '0;
            wr_done_d = '0;
            outst_d   = '0;
        end else begin
            if (rd_cmpl_ok) rd_done_d = rd_done_q + 1'b1;
            if (wr_cmpl_ok) wr_done_d = wr_done_q + 1'b1;
            unique case ({rd_fire, wr_cmpl_ok})
                2'b10:   outst_d = outst_q + 1'b1;
                2'b01:   outst_d = outst_q - 1'b1;
                default: outst_d = outst_q;
            endcase
        end

        unique case (state_q)
            StIdle: if (start_acc) state_d = (s_blocks == '0) ? StDone : StRun;
            StRun:  if (wr_done_q == len_q) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= StIdle;
            len_q     <= '0;
            rd_done_q <= '0;
            wr_done_q <= '0;
            outst_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rd_done_q <= rd_done_d;
            wr_done_q <= wr_done_d;
            outst_q   <= outst_d;
            err_q     <= err_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign err  = err_q;

`ifdef EVAL_EXP_SCHED_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (start_acc) begin
            cyc_d = '0;
        end else if (busy && (cyc_q != '1)) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cycle_count = cyc_q;
`endif

endmodule
